// File: rtl/tcp_rx_to_bus_if.sv
// Signal bundle between the SiTCP Rx FIFO / basil bus and the TCP-to-bus bridge.
// The bridge is the bus master; the environment (FIFO, bus slaves, top mux) is the slave side.
interface tcp_rx_to_bus_if #(
  parameter int unsigned ABUSWIDTH = 32
) ();
  logic                 USR_ACTIVE;
  logic                 USR_RX_EMPTY;
  logic                 USR_RX_RE;
  logic                 USR_RX_RV;
  logic [7:0]           USR_RX_RD;
  logic                 BUS_WR;
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_ACTIVE;
  logic [15:0]          FRAME_CNT;
  logic [7:0]           ERR_CNT;

  modport master (
    input  USR_ACTIVE, USR_RX_EMPTY, USR_RX_RV, USR_RX_RD,
    output USR_RX_RE, BUS_WR, BUS_ADD, BUS_DATA_OUT, BUS_ACTIVE, FRAME_CNT, ERR_CNT
  );

  modport slave (
    output USR_ACTIVE, USR_RX_EMPTY, USR_RX_RV, USR_RX_RD,
    input  USR_RX_RE, BUS_WR, BUS_ADD, BUS_DATA_OUT, BUS_ACTIVE, FRAME_CNT, ERR_CNT
  );
endinterface

// File: rtl/tcp_rx_to_bus.sv
// TCP receive path: parses framed write commands from the SiTCP Rx byte stream
// (sync, 4-byte address, 2-byte length, payload) into byte-wide bus writes.
module tcp_rx_to_bus #(
  parameter int unsigned ABUSWIDTH = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input logic             BUS_CLK,
  input logic             BUS_RST,
  tcp_rx_to_bus_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StLen, StData} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [15:0]          len_q, len_d;
  logic [1:0]           idx_q, idx_d;
  logic [31:0]          tmo_q, tmo_d;
  logic                 wr_q, wr_d;
  logic [ABUSWIDTH-1:0] add_q, add_d;
  logic [7:0]           data_q, data_d;
  logic [15:0]          frame_q, frame_d;
  logic [7:0]           err_q, err_d;
  logic                 err_inc;
  logic                 rx_vld;
  logic                 tmo_hit;
  logic                 abort;
  logic [15:0]          len_new;

  // A byte landing after the connection dropped (pipelined RE) is discarded.
  assign rx_vld  = bus.USR_RX_RV & bus.USR_ACTIVE;
  assign tmo_hit = (TIMEOUT != 0) && !rx_vld && (tmo_q == TIMEOUT - 1);
  assign abort   = (state_q != StIdle) && (!bus.USR_ACTIVE || tmo_hit);
  assign len_new = {len_q[7:0], bus.USR_RX_RD};

  assign bus.USR_RX_RE    = bus.USR_ACTIVE & ~bus.USR_RX_EMPTY;
  assign bus.BUS_WR       = wr_q;
  assign bus.BUS_ADD      = add_q;
  assign bus.BUS_DATA_OUT = data_q;
  // Covers the cycle of the final write, after the FSM is already back in idle.
  assign bus.BUS_ACTIVE   = (state_q != StIdle) | wr_q;
  assign bus.FRAME_CNT    = frame_q;
  assign bus.ERR_CNT      = err_q;

  // Frame parser next-state, write generation and counter updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    idx_d   = idx_q;
    tmo_d   = '0;
    wr_d    = 1'b0;
    add_d   = add_q;
    data_d  = data_q;
    frame_d = frame_q;
    err_d   = err_q;
    err_inc = 1'b0;

    if (state_q != StIdle) begin
      tmo_d = rx_vld ? 32'd0 : tmo_q + 32'd1;
    end

    if (abort) begin
      // Abort beats a byte arriving in the same cycle.
      state_d = StIdle;
      tmo_d   = '0;
      err_inc = 1'b1;
    end else if (rx_vld) begin
      unique case (state_q)
        StIdle: begin
          if (bus.USR_RX_RD == SYNC_BYTE) begin
            state_d = StAddr;
            idx_d   = 2'd0;
          end else begin
            err_inc = 1'b1;
          end
        end
        StAddr: begin
          addr_d = {addr_q[23:0], bus.USR_RX_RD};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = StLen;
            idx_d   = 2'd0;
          end
        end
        StLen: begin
          len_d = len_new;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            idx_d = 2'd0;
            if (len_new == 16'd0) begin
              frame_d = frame_q + 16'd1;
              state_d = StIdle;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          wr_d   = 1'b1;
          add_d  = addr_q[ABUSWIDTH-1:0];
          data_d = bus.USR_RX_RD;
          addr_d = addr_q + 32'd1;
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) begin
            frame_d = frame_q + 16'd1;
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      add_q   <= add_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tcp_rx_to_bus.sv
// Bench for tcp_rx_to_bus: two instances (32- and 16-bit address) share one Rx stream.
// A FIFO model answers RE with RV one cycle later; a frame-buffer reference model
// predicts every output each cycle.
module tb_tcp_rx_to_bus;

  localparam int unsigned TMO  = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tcp_rx_to_bus_if #(.ABUSWIDTH(32)) if32 ();
  tcp_rx_to_bus_if #(.ABUSWIDTH(16)) if16 ();

  tcp_rx_to_bus #(.ABUSWIDTH(32), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) u_dut32 (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (if32.master)
  );

  tcp_rx_to_bus #(.ABUSWIDTH(16), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)) u_dut16 (
    .BUS_CLK (clk),
    .BUS_RST (rst),
    .bus     (if16.master)
  );

  typedef struct packed {
    logic       act;
    logic       emp;
    logic       rst;
    logic [7:0] b;
  } stim_t;

  stim_t       stim_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model state: bytes of the frame in progress (empty = waiting for sync).
  logic [7:0]  fbuf[$];
  int          stall;
  logic        m_wr;
  logic [31:0] m_add;
  logic [7:0]  m_data;
  logic [15:0] m_frame;
  logic [7:0]  m_err;
  logic        m_active;
  logic        exp_re;
  logic        prev_rd_en;
  logic [7:0]  prev_b;
  logic [31:0] log32[$];
  logic [15:0] log16[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    stim_q.push_back('{act: 1'b1, emp: 1'b0, rst: 1'b0, b: b});
  endtask

  task automatic put_gap(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back('{act: 1'b1, emp: 1'b1, rst: 1'b0, b: 8'h00});
  endtask

  task automatic put_off(input int n);
    for (int i = 0; i < n; i++) stim_q.push_back('{act: 1'b0, emp: 1'b0, rst: 1'b0, b: 8'h00});
  endtask

  task automatic put_rst();
    stim_q.push_back('{act: 1'b0, emp: 1'b1, rst: 1'b1, b: 8'h00});
  endtask

  task automatic put_hdr(input logic [31:0] addr, input logic [15:0] len);
    put_byte(SYNC);
    put_byte(addr[31:24]);
    put_byte(addr[23:16]);
    put_byte(addr[15:8]);
    put_byte(addr[7:0]);
    put_byte(len[15:8]);
    put_byte(len[7:0]);
  endtask

  // Frame with random payload; optional connection drop or long stall after byte index.
  task automatic put_frame(input logic [31:0] addr, input int len, input int gap_max,
                           input int drop_at, input int stall_at, input int stall_len);
    logic [7:0]  fb[$];
    logic [15:0] l16;
    l16 = 16'(len);
    fb = {SYNC, addr[31:24], addr[23:16], addr[15:8], addr[7:0], l16[15:8], l16[7:0]};
    for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
    for (int i = 0; i < fb.size(); i++) begin
      put_byte(fb[i]);
      if (i == drop_at) begin
        put_gap($urandom_range(0, 1));
        put_off($urandom_range(1, 3));
        return;
      end
      if (i == stall_at) begin
        put_gap(stall_len);
        if (stall_len >= int'(TMO)) return;
      end else begin
        put_gap($urandom_range(0, gap_max));
      end
    end
  endtask

  task automatic model_reset();
    fbuf.delete();
    stall      = 0;
    m_wr       = 1'b0;
    m_add      = '0;
    m_data     = '0;
    m_frame    = '0;
    m_err      = '0;
    m_active   = 1'b0;
    exp_re     = 1'b0;
    prev_rd_en = 1'b0;
    prev_b     = '0;
  endtask

  task automatic bump_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  task automatic finish_frame();
    m_frame = m_frame + 16'd1;
    fbuf.delete();
  endtask

  // Append a header/payload byte; payload byte k (from 0) writes to base address + k.
  task automatic take(input logic [7:0] d);
    int          n;
    int          len;
    logic [31:0] base;
    fbuf.push_back(d);
    n = fbuf.size();
    if (n < 7) return;
    len = int'({fbuf[5], fbuf[6]});
    if (n == 7) begin
      if (len == 0) finish_frame();
      return;
    end
    base   = {fbuf[1], fbuf[2], fbuf[3], fbuf[4]};
    m_wr   = 1'b1;
    m_add  = base + 32'(n - 8);
    m_data = d;
    if (n - 7 == len) finish_frame();
  endtask

  task automatic model_step(input logic r, input logic a, input logic v, input logic [7:0] d);
    logic vld;
    if (r) begin
      model_reset();
      return;
    end
    vld  = v & a;
    m_wr = 1'b0;
    if (fbuf.size() != 0) begin
      stall = vld ? 0 : stall + 1;
      if (!a || stall == int'(TMO)) begin
        fbuf.delete();
        bump_err();
      end else if (vld) begin
        take(d);
      end
    end else if (vld) begin
      if (d == SYNC) begin
        fbuf.push_back(d);
        stall = 0;
      end else begin
        bump_err();
      end
    end
    m_active = (fbuf.size() != 0) || m_wr;
  endtask

  task automatic drive(input logic a, input logic e, input logic v, input logic [7:0] d);
    if32.USR_ACTIVE = a; if32.USR_RX_EMPTY = e; if32.USR_RX_RV = v; if32.USR_RX_RD = d;
    if16.USR_ACTIVE = a; if16.USR_RX_EMPTY = e; if16.USR_RX_RV = v; if16.USR_RX_RD = d;
  endtask

  task automatic check_outputs();
    check_eq("re32",   64'(if32.USR_RX_RE),    64'(exp_re));
    check_eq("wr32",   64'(if32.BUS_WR),       64'(m_wr));
    check_eq("add32",  64'(if32.BUS_ADD),      64'(m_add));
    check_eq("dat32",  64'(if32.BUS_DATA_OUT), 64'(m_data));
    check_eq("act32",  64'(if32.BUS_ACTIVE),   64'(m_active));
    check_eq("frm32",  64'(if32.FRAME_CNT),    64'(m_frame));
    check_eq("err32",  64'(if32.ERR_CNT),      64'(m_err));
    check_eq("re16",   64'(if16.USR_RX_RE),    64'(exp_re));
    check_eq("wr16",   64'(if16.BUS_WR),       64'(m_wr));
    check_eq("add16",  64'(if16.BUS_ADD),      64'(m_add[15:0]));
    check_eq("dat16",  64'(if16.BUS_DATA_OUT), 64'(m_data));
    check_eq("act16",  64'(if16.BUS_ACTIVE),   64'(m_active));
    check_eq("frm16",  64'(if16.FRAME_CNT),    64'(m_frame));
    check_eq("err16",  64'(if16.ERR_CNT),      64'(m_err));
    if (if32.BUS_WR === 1'b1) log32.push_back(if32.BUS_ADD);
    if (if16.BUS_WR === 1'b1) log16.push_back(if16.BUS_ADD);
  endtask

  // One clock per stimulus entry; the FIFO returns the byte read last cycle.
  task automatic run();
    stim_t       e;
    logic        rv_v;
    logic [7:0]  rd_v;
    log32.delete();
    log16.delete();
    while (stim_q.size() != 0) begin
      e = stim_q.pop_front();
      @(negedge clk);
      check_outputs();
      rv_v = prev_rd_en;
      rd_v = prev_rd_en ? prev_b : 8'($urandom);
      rst  = e.rst;
      drive(e.act, e.emp, rv_v, rd_v);
      exp_re     = e.act & ~e.emp;
      prev_rd_en = exp_re;
      prev_b     = e.b;
      model_step(e.rst, e.act, rv_v, rd_v);
    end
  endtask

  task automatic run_random();
    int          kind;
    int          len;
    int          nb;
    logic [31:0] a;
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFD;
      len  = $urandom_range(0, 6);
      nb   = 7 + len;
      case (kind)
        0:       put_byte(8'($urandom_range(0, 8'hA4)));
        1:       put_frame(a, len, 2, $urandom_range(1, nb - 1), -1, 0);
        2:       put_frame(a, len, 2, -1, $urandom_range(0, nb - 2), $urandom_range(13, 18));
        default: put_frame(a, len, 2, -1, -1, 0);
      endcase
      put_gap($urandom_range(1, 3));
    end
    run();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_wr",  64'(if32.BUS_WR),     64'd0);
    check_eq("rst_act", 64'(if32.BUS_ACTIVE), 64'd0);
    check_eq("rst_add", 64'(if32.BUS_ADD),    64'd0);
    check_eq("rst_frm", 64'(if32.FRAME_CNT),  64'd0);
    check_eq("rst_err", 64'(if32.ERR_CNT),    64'd0);
    rst = 1'b0;

    // Basic three-byte write.
    put_hdr(32'h0000_0100, 16'd3);
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33);
    put_gap(3);
    run();
    check_eq("t1_nwr", 64'(log32.size()), 64'd3);
    check_eq("t1_a0",  64'(log32[0]), 64'h100);
    check_eq("t1_a2",  64'(log32[2]), 64'h102);
    check_eq("t1_frm", 64'(if32.FRAME_CNT), 64'd1);
    check_eq("t1_err", 64'(if32.ERR_CNT),   64'd0);

    // Two junk bytes ahead of a frame.
    put_byte(8'h00); put_byte(8'h7F);
    put_frame(32'h0000_0040, 2, 1, -1, -1, 0);
    put_gap(3);
    run();
    check_eq("t2_err", 64'(if32.ERR_CNT),   64'd2);
    check_eq("t2_frm", 64'(if32.FRAME_CNT), 64'd2);

    // Address wrap.
    put_hdr(32'hFFFF_FFFF, 16'd2);
    put_byte(8'hC1); put_byte(8'hC2);
    put_gap(3);
    run();
    check_eq("t3_n16", 64'(log16.size()), 64'd2);
    check_eq("t3_a16_0", 64'(log16[0]), 64'hFFFF);
    check_eq("t3_a16_1", 64'(log16[1]), 64'h0000);
    check_eq("t3_a32_1", 64'(log32[1]), 64'h0000_0000);

    // Zero-length frame.
    put_hdr(32'h0000_0500, 16'd0);
    put_gap(3);
    run();
    check_eq("t4_nwr", 64'(log32.size()), 64'd0);
    check_eq("t4_frm", 64'(if32.FRAME_CNT), 64'd4);
    check_eq("t4_act", 64'(if32.BUS_ACTIVE), 64'd0);

    // Connection drop after two of five payload bytes, then a clean frame.
    put_hdr(32'h0000_0200, 16'd5);
    put_byte(8'hAA); put_byte(8'hBB);
    put_gap(1); put_off(2); put_gap(2);
    run();
    check_eq("t5_nwr", 64'(log32.size()), 64'd2);
    check_eq("t5_err", 64'(if32.ERR_CNT), 64'd3);
    check_eq("t5_act", 64'(if32.BUS_ACTIVE), 64'd0);
    put_hdr(32'h0000_0300, 16'd1);
    put_byte(8'hCC);
    put_gap(3);
    run();
    check_eq("t5_a",   64'(log32[0]), 64'h300);
    check_eq("t5_frm", 64'(if32.FRAME_CNT), 64'd5);

    // Header stall at the timeout limit aborts; one cycle shorter does not.
    put_frame(32'h0000_0600, 1, 0, -1, 2, 16);
    put_gap(2);
    run();
    check_eq("t6_err", 64'(if32.ERR_CNT),   64'd4);
    check_eq("t6_frm", 64'(if32.FRAME_CNT), 64'd5);
    put_frame(32'h0000_0700, 1, 0, -1, 2, 15);
    put_gap(3);
    run();
    check_eq("t6b_err", 64'(if32.ERR_CNT),   64'd4);
    check_eq("t6b_frm", 64'(if32.FRAME_CNT), 64'd6);

    run_random();

    // Error counter saturation.
    for (int i = 0; i < 260; i++) put_byte(8'h5A);
    put_gap(2);
    run();
    check_eq("sat_err", 64'(if32.ERR_CNT), 64'd255);

    // Reset in the middle of a header.
    put_byte(SYNC); put_byte(8'h01); put_byte(8'h02);
    put_gap(1); put_rst(); put_gap(2);
    run();
    check_eq("mrst_frm", 64'(if32.FRAME_CNT),  64'd0);
    check_eq("mrst_err", 64'(if32.ERR_CNT),    64'd0);
    check_eq("mrst_act", 64'(if32.BUS_ACTIVE), 64'd0);
    put_hdr(32'h0000_0040, 16'd2);
    put_byte(8'h01); put_byte(8'h02);
    put_gap(3);
    run();
    check_eq("mrst_frm2", 64'(if32.FRAME_CNT), 64'd1);
    check_eq("mrst_nwr",  64'(log32.size()),   64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
